// File: rtl/spi93_pkg.sv
// Shared opcodes, extended sub-codes and FSM encoding for the 93LC46 (x8)
// Microwire responder.
package spi93_pkg;

    localparam logic [1:0] OP_EXT   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    // Extended codes live in the two address MSBs when the opcode is 00
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OPC,
        ST_ADDR,
        ST_DIN,
        ST_DOUT,
        ST_PROG
    } state_t;

    typedef enum logic [1:0] {
        CMD_WRITE,
        CMD_ERASE,
        CMD_WRAL,
        CMD_ERAL
    } cmd_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous bus pin, with an optional
// rise-edge strobe taken from a third register.
module sync_edge #(
    parameter bit RISE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic re
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign q  = sync_p1;
    assign re = RISE_EN ? (sync_p1 & ~sync_p2) : 1'b0;

endmodule

// File: rtl/spi_93lc46_slave.sv
// 93LC46 (x8) Microwire EEPROM responder with busy/ready program cycle.
// Optional bulk ERAL/WRAL opcodes are built when SPI93_BULK_EN is defined.
module spi_93lc46_slave
    import spi93_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 8,
    parameter int WRITE_CYCLES = 250000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic cs,
    input  logic sck,
    input  logic mo,
    output logic mi,
    output logic busy,
    output logic ewen
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXB   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W  = $clog2(MAXB) + 1;
    localparam int PCNT_W = $clog2(WRITE_CYCLES + 1);

    logic cs_s, sck_re, mo_s;
    logic unused_cs_re, unused_mo_re, unused_sck_s;

    sync_edge #(.RISE_EN(1'b0)) u_sync_cs (
        .clk(Clk), .rst_n(Rst_n), .d(cs), .q(cs_s), .re(unused_cs_re)
    );
    sync_edge #(.RISE_EN(1'b1)) u_sync_sck (
        .clk(Clk), .rst_n(Rst_n), .d(sck), .q(unused_sck_s), .re(sck_re)
    );
    sync_edge #(.RISE_EN(1'b0)) u_sync_mo (
        .clk(Clk), .rst_n(Rst_n), .d(mo), .q(mo_s), .re(unused_mo_re)
    );

    state_t              state, state_nxt;
    cmd_t                cmd, cmd_nxt;
    logic                armed, armed_nxt;
    logic                done, done_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [1:0]          opc, opc_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [DATA_W-1:0]   sreg, sreg_nxt;
    logic [PCNT_W-1:0]   prog_cnt, prog_cnt_nxt;
    logic                mi_nxt, busy_nxt, ewen_nxt;
`ifdef SPI93_BULK_EN
    logic                sweeping, sweeping_nxt;
    logic [ADDR_W-1:0]   sweep_a, sweep_a_nxt;
`endif

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [ADDR_W-1:0]   addr_full, addr_inc;

    // Non-volatile emulation: contents survive reset, erased at power-up
    logic [DATA_W-1:0]   mem [DEPTH] = '{default: {DATA_W{1'b1}}};

    assign addr_full = {addr[ADDR_W-2:0], mo_s};
    assign addr_inc  = addr + 1'b1;

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        armed_nxt    = armed;
        done_nxt     = done;
        bit_cnt_nxt  = bit_cnt;
        opc_nxt      = opc;
        addr_nxt     = addr;
        sreg_nxt     = sreg;
        prog_cnt_nxt = prog_cnt;
        mi_nxt       = mi;
        busy_nxt     = busy;
        ewen_nxt     = ewen;
        mem_we       = 1'b0;
        mem_wa       = addr;
        mem_wd       = sreg;
`ifdef SPI93_BULK_EN
        sweeping_nxt = sweeping;
        sweep_a_nxt  = sweep_a;
`endif

        // A cs drop beats any coincident sck edge
        if (state != ST_IDLE && state != ST_PROG && !cs_s) begin
            mi_nxt       = 1'b1;
            armed_nxt    = 1'b0;
            done_nxt     = 1'b0;
            prog_cnt_nxt = '0;
`ifdef SPI93_BULK_EN
            sweeping_nxt = 1'b0;
`endif
            if (armed && ewen) begin
                state_nxt = ST_PROG;
                busy_nxt  = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    mi_nxt = 1'b1;
                    if (cs_s && !busy) begin
                        state_nxt   = ST_START;
                        bit_cnt_nxt = '0;
                        armed_nxt   = 1'b0;
                        done_nxt    = 1'b0;
                    end
                end
                ST_START: begin
                    mi_nxt = 1'b1;
                    if (sck_re && mo_s) begin
                        state_nxt   = ST_OPC;
                        bit_cnt_nxt = '0;
                    end
                end
                ST_OPC: begin
                    if (sck_re) begin
                        opc_nxt = {opc[0], mo_s};
                        if (bit_cnt == CNT_W'(1)) begin
                            state_nxt   = ST_ADDR;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_re && !done) begin
                        addr_nxt    = addr_full;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt_nxt = '0;
                            case (opc)
                                OP_READ: begin
                                    state_nxt = ST_DOUT;
                                    sreg_nxt  = mem[addr_full];
                                    mi_nxt    = 1'b0;
                                end
                                OP_WRITE: begin
                                    state_nxt = ST_DIN;
                                    cmd_nxt   = CMD_WRITE;
                                end
                                OP_ERASE: begin
                                    cmd_nxt   = CMD_ERASE;
                                    armed_nxt = 1'b1;
                                    done_nxt  = 1'b1;
                                end
                                default: begin
                                    done_nxt = 1'b1;
                                    case (addr_full[ADDR_W-1 -: 2])
                                        EXT_EWEN: ewen_nxt = 1'b1;
                                        EXT_EWDS: ewen_nxt = 1'b0;
`ifdef SPI93_BULK_EN
                                        EXT_ERAL: begin
                                            cmd_nxt   = CMD_ERAL;
                                            armed_nxt = 1'b1;
                                        end
                                        EXT_WRAL: begin
                                            state_nxt = ST_DIN;
                                            cmd_nxt   = CMD_WRAL;
                                            done_nxt  = 1'b0;
                                        end
`endif
                                        default: ;
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                ST_DIN: begin
                    if (sck_re && !done) begin
                        sreg_nxt    = {sreg[DATA_W-2:0], mo_s};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            armed_nxt = 1'b1;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_DOUT: begin
                    if (sck_re) begin
                        mi_nxt   = sreg[DATA_W-1];
                        sreg_nxt = {sreg[DATA_W-2:0], 1'b0};
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            // Sequential read: next word follows without a dummy bit
                            bit_cnt_nxt = '0;
                            addr_nxt    = addr_inc;
                            sreg_nxt    = mem[addr_inc];
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PROG: begin
                    mi_nxt = !cs_s;
`ifdef SPI93_BULK_EN
                    if (sweeping) begin
                        mem_we      = 1'b1;
                        mem_wa      = sweep_a;
                        mem_wd      = (cmd == CMD_ERAL) ? {DATA_W{1'b1}} : sreg;
                        sweep_a_nxt = sweep_a + 1'b1;
                        if (sweep_a == {ADDR_W{1'b1}}) begin
                            sweeping_nxt = 1'b0;
                            state_nxt    = ST_IDLE;
                            busy_nxt     = 1'b0;
                            mi_nxt       = 1'b1;
                        end
                    end else
`endif
                    if (prog_cnt == PCNT_W'(WRITE_CYCLES - 1)) begin
`ifdef SPI93_BULK_EN
                        if (cmd == CMD_WRAL || cmd == CMD_ERAL) begin
                            sweeping_nxt = 1'b1;
                            sweep_a_nxt  = '0;
                        end else
`endif
                        begin
                            mem_we    = 1'b1;
                            mem_wd    = (cmd == CMD_ERASE) ? {DATA_W{1'b1}} : sreg;
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                            mi_nxt    = 1'b1;
                        end
                    end else begin
                        prog_cnt_nxt = prog_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            cmd      <= CMD_WRITE;
            armed    <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            opc      <= '0;
            addr     <= '0;
            sreg     <= '0;
            prog_cnt <= '0;
            mi       <= 1'b1;
            busy     <= 1'b0;
            ewen     <= 1'b0;
`ifdef SPI93_BULK_EN
            sweeping <= 1'b0;
            sweep_a  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            armed    <= armed_nxt;
            done     <= done_nxt;
            bit_cnt  <= bit_cnt_nxt;
            opc      <= opc_nxt;
            addr     <= addr_nxt;
            sreg     <= sreg_nxt;
            prog_cnt <= prog_cnt_nxt;
            mi       <= mi_nxt;
            busy     <= busy_nxt;
            ewen     <= ewen_nxt;
`ifdef SPI93_BULK_EN
            sweeping <= sweeping_nxt;
            sweep_a  <= sweep_a_nxt;
`endif
        end
    end

    // Reset during a program cycle must leave the array untouched
    always_ff @(posedge Clk) begin
        if (mem_we && Rst_n)
            mem[mem_wa] <= mem_wd;
    end

endmodule

// File: doc/spi_93lc46_slave.md
# spi_93lc46_slave

Microwire (93LC46, x8 organisation) serial-EEPROM responder: it is the device end of the 3-wire-plus-CS bus that the UART-to-SPI bridge drives as master. It oversamples `cs`, `sck` and `mo` on the system clock, decodes start bit, opcode and address, and serves READ, WRITE, ERASE, EWEN and EWDS from a 128×8 array. It models the busy/ready programming cycle. Used as an on-FPGA loopback target for bridge bring-up and as a synthesizable bench model.

## Interface
- `ADDR_W`, 7, address bits (array depth 2^ADDR_W)
- `DATA_W`, 8, data bits per word
- `WRITE_CYCLES`, 250000, Clk cycles per program operation (5 ms at 50 MHz)

- `Clk` input 1 system clock (50 MHz)
- `Rst_n` input 1 synchronous, active-low reset
- `cs` input 1 chip select from master, active high, asynchronous to Clk
- `sck` input 1 serial clock from master, asynchronous
- `mo` input 1 master-out serial data (device DI)
- `mi` output 1 master-in serial data (device DO)
- `busy` output 1 program cycle in progress
- `ewen` output 1 erase/write enable latch

## Operation
- `cs`, `sck` and `mo` each pass through a 2-flop synchronizer. A third register on `sck` gives the rise edge `sck_re`. All bus sampling uses `sck_re` only.
- FSM states: IDLE, START, OPC, ADDR, DIN, DOUT, PROG.
- IDLE goes to START when synchronized `cs`=1 and not `busy`.
- START: on `sck_re` with `mo`=1, go to OPC. `mo`=0 clocks are ignored (leading zeros).
- OPC: capture 2 bits MSB first, then go to ADDR.
- ADDR: capture ADDR_W bits MSB first. After the last bit, decode:
  - READ (10): go to DOUT, with `mi`=0 as dummy bit.
  - WRITE (01): go to DIN.
  - ERASE (11): go to PROG armed, if `ewen`.
  - 00 with A6:A5=11 (EWEN): set `ewen`.
  - 00 with A6:A5=00 (EWDS): clear `ewen`.
  - Other 00 codes: see Configuration.
- DIN: capture DATA_W bits MSB first. After the last bit the command is armed.
- DOUT: on each subsequent `sck_re`, shift out the next data bit MSB first. After the LSB, the address increments (wraps 127→0) and the next word follows with no dummy bit (sequential read).
- When synchronized `cs` falls:
  - If a write-class command is armed and `ewen`=1, go to PROG with `busy`=1.
  - Otherwise go to IDLE. An incomplete command is discarded and causes no array change.
- WRITE or ERASE issued while `ewen`=0: ignored, `busy` stays 0.
- PROG: counts WRITE_CYCLES, then commits the single word (ERASE writes 8'hFF). Bulk operations then sweep addresses 0..2^ADDR_W−1, one per Clk. `busy` falls on the Clk after the last array write, then the FSM returns to IDLE.
- Ready/busy status:
  - While `cs`=1 and `busy`=1, `mi`=0.
  - While `cs`=1 in START after a program cycle, `mi`=1 until the start bit is seen.
- Array is not reset (non-volatile emulation). Power-up contents are 8'hFF via initialisation. Reset mid-PROG aborts the program and leaves the target word(s) unchanged.

## Timing
- Reset values: `mi`=1, `busy`=0, `ewen`=0, FSM=IDLE, all shift and count registers 0.
- Pin-to-`sck_re` latency is 3 Clk cycles.
- `mi` updates on the Clk cycle after `sck_re`, i.e. 4 Clk cycles after the pin rises. It is stable well before the next master rise edge.
- Master constraints: `sck` high and low times ≥4 Clk each. `cs` low time ≥4 Clk.
- If `cs` falls in the same Clk as `sck_re`, `cs` wins: the bit is not sampled.
- When `cs`=0, `mi`=1.

## Configuration
- `SPI93_BULK_EN` defined: two bulk opcodes are decoded.
  - ERAL (00, A6:A5=10) sets every word to 8'hFF.
  - WRAL (00, A6:A5=01, followed by DATA_W bits) writes that data to every word.
  - Both require `ewen` and take WRITE_CYCLES + 2^ADDR_W Clk cycles.
- Undefined: these two codes return the FSM to IDLE at `cs` fall with no effect. The sweep counter is not built.

## Structure
- Shared package `spi93_pkg`: opcode constants (OP_READ, OP_WRITE, OP_ERASE, OP_EXT), extended sub-codes (EWEN, EWDS, ERAL, WRAL), FSM state encoding.
- Sub-module `sync_edge`: 2-flop synchronizer with an optional rise-edge output. It is instantiated three times (`cs`, `sck`, `mo`).

## Test plan
- WRITE data blocked by default: reset, then WRITE addr 0x05 data 0x3C with `ewen`=0, then READ 0x05 → `busy` never rises, read returns 0xFF.
- WRITE then READ: EWEN, then WRITE 0x05/0x3C. Expect `busy` high for WRITE_CYCLES (test value 20) and `mi`=0 with `cs` high, then `mi`=1. A following READ 0x05 returns dummy 0 then 0x3C.
- Sequential read wrap: pre-load 0x7F=0xA5 and 0x00=0x5A, then READ 0x7F for 16 data clocks → 0xA5 then 0x5A.
- Abort cases: EWEN; WRITE 0x10 with `cs` dropped after 4 data bits → 0x10 stays 0xFF. Assert `Rst_n` mid-PROG of WRITE 0x11/0x22 → `busy`=0, `ewen`=0, 0x11 stays 0xFF.
- Erase disable: EWDS then ERASE 0x05 → no `busy`, 0x05 keeps 0x3C. EWEN then ERASE 0x05 → reads 0xFF.
- `SPI93_BULK_EN`: EWEN, WRAL 0x96 → `busy` for 20+128 cycles, addresses 0x00 and 0x7F read 0x96. ERAL → all words 0xFF. Without the macro, WRAL leaves the array unchanged.
